// File: rtl/scan_sel_pkg.sv
// Shared constants and state encoding for the scan select generator.
package scan_sel_pkg;

   localparam int N_CH  = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/scan_next_idx.sv
// Combinational search for the next enabled channel strictly above cur,
// wrapping circularly. The last candidate examined is cur itself, so a
// single-bit mask returns cur with wrapped=1. A zero mask leaves nxt=cur.
module scan_next_idx
   import scan_sel_pkg::*;
(
   input  logic [IDX_W-1:0] cur,
   input  logic [N_CH-1:0]  mask,
   output logic [IDX_W-1:0] nxt,
   output logic             wrapped
);

   logic [IDX_W-1:0] cand;
   logic             found;

   // first set mask bit walking upward from cur+1, modulo N_CH
   always_comb begin
      nxt     = cur;
      wrapped = 1'b0;
      found   = 1'b0;
      cand    = cur;
      for (int k = 1; k <= N_CH; k++) begin
         cand = cur + IDX_W'(k);
         if (!found && mask[cand]) begin
            found   = 1'b1;
            nxt     = cand;
            wrapped = (cand <= cur);
         end
      end
   end

endmodule

// File: rtl/scan_sel_gen.sv
// Scan select generator: steps a 2-bit decoder select through the enabled
// channels in mask, holding each for dwell+1 cycles, and pulses wrap when
// the scan returns to a lower or equal index.
// Optional macro SCAN_SEL_ONEHOT_EN adds a registered one-hot select sel_oh.
//
// state  | meaning
// S_IDLE | no live index; sel holds last value, waiting for en with mask!=0
// S_RUN  | sel is live; cnt counts cycles spent on the current index
module scan_sel_gen
   import scan_sel_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [N_CH-1:0]    mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [IDX_W-1:0]   sel,
   output logic               sel_valid,
   output logic               wrap
`ifdef SCAN_SEL_ONEHOT_EN
   ,
   output logic [N_CH-1:0]    sel_oh
`endif
);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   sel_q, sel_d;
   logic               valid_q, valid_d;
   logic               wrap_q, wrap_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]   srch_cur;
   logic [IDX_W-1:0]   nxt;
   logic               wrapped;
   logic               mask_nz;
   logic               hold_done;

   // searching from the top index yields the lowest set bit on entry to RUN
   assign srch_cur  = (state_q == S_RUN) ? sel_q : IDX_W'(N_CH - 1);
   assign mask_nz   = |mask;
   assign hold_done = (cnt_q >= dwell);

   scan_next_idx u_next (
      .cur     (srch_cur),
      .mask    (mask),
      .nxt     (nxt),
      .wrapped (wrapped)
   );

   // state register plus registered outputs and dwell counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         cnt_q   <= cnt_d;
      end
   end

   // next-state: leave RUN on en low or on an advance that finds no channel
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (en && mask_nz) state_d = S_RUN;
         S_RUN:   if (!en || (hold_done && !mask_nz)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // next values of sel, sel_valid, wrap and cnt for the coming edge
   always_comb begin
      sel_d   = sel_q;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      cnt_d   = '0;
      if (state_d == S_RUN) begin
         valid_d = 1'b1;
         if (state_q == S_IDLE) begin
            sel_d = nxt;
         end else if (!hold_done) begin
            cnt_d = cnt_q + DWELL_W'(1);
         end else begin
            sel_d  = nxt;
            wrap_d = wrapped;
         end
      end
   end

   assign sel       = sel_q;
   assign sel_valid = valid_q;
   assign wrap      = wrap_q;

`ifdef SCAN_SEL_ONEHOT_EN
   logic [N_CH-1:0] oh_q, oh_d;

   assign oh_d = valid_d ? (N_CH'(1) << sel_d) : '0;

   // one-hot select registered alongside sel so both change on the same edge
   always_ff @(posedge clk) begin
      if (rst) oh_q <= '0;
      else     oh_q <= oh_d;
   end

   assign sel_oh = oh_q;
`endif

endmodule

// File: tb/tb_scan_sel_gen.sv
// Self-checking bench for scan_sel_gen: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_scan_sel_gen;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [3:0]    mask;
   logic [DW-1:0] dwell;
   logic [1:0]    sel;
   logic          sel_valid;
   logic          wrap;
`ifdef SCAN_SEL_ONEHOT_EN
   logic [3:0]    sel_oh;
`endif

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   scan_sel_gen #(.DWELL_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mask      (mask),
      .dwell     (dwell),
      .sel       (sel),
      .sel_valid (sel_valid),
      .wrap      (wrap)
`ifdef SCAN_SEL_ONEHOT_EN
      ,
      .sel_oh    (sel_oh)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: live flag, index, cycles spent on the index, wrap
   bit m_valid = 1'b0;
   int m_sel   = 0;
   int m_age   = 0;
   bit m_wrap  = 1'b0;

   function automatic int lowest_set(input logic [3:0] m);
      for (int i = 0; i < 4; i++) if (m[i]) return i;
      return 0;
   endfunction

   function automatic int next_set(input int cur, input logic [3:0] m);
      for (int k = 1; k <= 4; k++) if (m[(cur + k) % 4]) return (cur + k) % 4;
      return cur;
   endfunction

   always @(posedge clk) begin
      int nw;
      if (rst) begin
         m_valid = 0; m_sel = 0; m_age = 0; m_wrap = 0;
      end else if (!m_valid) begin
         m_wrap = 0;
         if (en && mask != 0) begin
            m_valid = 1; m_sel = lowest_set(mask); m_age = 0;
         end
      end else if (!en) begin
         m_valid = 0; m_wrap = 0; m_age = 0;
      end else if (m_age < int'(dwell)) begin
         m_age++; m_wrap = 0;
      end else if (mask == 0) begin
         m_valid = 0; m_wrap = 0; m_age = 0;
      end else begin
         nw     = next_set(m_sel, mask);
         m_wrap = (nw <= m_sel);
         m_sel  = nw;
         m_age  = 0;
      end
   end

   // every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_sel", int'(sel), m_sel);
         check("model_valid", int'(sel_valid), int'(m_valid));
         check("model_wrap", int'(wrap), int'(m_wrap));
`ifdef SCAN_SEL_ONEHOT_EN
         check("model_oh", int'(sel_oh), m_valid ? (1 << m_sel) : 0);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int seq28 [13] = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
      int seq29 [5]  = '{1,3,1,3,1};
      int wrp29 [5]  = '{0,0,1,0,1};

      rst = 1'b1; en = 1'b0; mask = 4'b0000; dwell = '0;
      tick(); tick();
      chk_en = 1'b1;
      check("rst_sel", int'(sel), 0);
      check("rst_valid", int'(sel_valid), 0);
      check("rst_wrap", int'(wrap), 0);

      // full mask, dwell 2
      rst = 1'b0; en = 1'b1; mask = 4'b1111; dwell = DW'(2);
      check("pre_en_valid", int'(sel_valid), 0);
      for (int i = 0; i < 13; i++) begin
         tick();
         check("seq28_sel", int'(sel), seq28[i]);
         check("seq28_valid", int'(sel_valid), 1);
         check("seq28_wrap", int'(wrap), (i == 12) ? 1 : 0);
      end

      // sparse mask, dwell 0
      do_reset();
      en = 1'b1; mask = 4'b1010; dwell = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("seq29_sel", int'(sel), seq29[i]);
         check("seq29_wrap", int'(wrap), wrp29[i]);
      end

      // single channel, dwell 3
      do_reset();
      en = 1'b1; mask = 4'b0100; dwell = DW'(3);
      for (int i = 0; i < 9; i++) begin
         tick();
         check("seq30_sel", int'(sel), 2);
`ifdef SCAN_SEL_ONEHOT_EN
         check("oh_run", int'(sel_oh), 4);
`endif
         check("seq30_wrap", int'(wrap), (i > 0 && i % 4 == 0) ? 1 : 0);
      end

      // en dropped on the second cycle of a hold at sel=1
      do_reset();
      en = 1'b1; mask = 4'b1111; dwell = DW'(5);
      for (int i = 0; i < 8; i++) tick();
      check("hold31_sel", int'(sel), 1);
      en = 1'b0;
      tick();
      check("drop31_valid", int'(sel_valid), 0);
      check("drop31_sel", int'(sel), 1);
`ifdef SCAN_SEL_ONEHOT_EN
      check("oh_idle", int'(sel_oh), 0);
`endif
      tick();
      check("idle31_sel", int'(sel), 1);
      en = 1'b1;
      tick();
      check("re31_sel", int'(sel), 0);
      check("re31_valid", int'(sel_valid), 1);

      // reset mid-hold at sel=3, cnt=4
      do_reset();
      en = 1'b1; mask = 4'b1000; dwell = DW'(5);
      for (int i = 0; i < 5; i++) tick();
      check("hold32_sel", int'(sel), 3);
      rst = 1'b1;
      tick();
      check("rst32_sel", int'(sel), 0);
      check("rst32_valid", int'(sel_valid), 0);
      check("rst32_wrap", int'(wrap), 0);
      rst = 1'b0;
      tick();
      check("post32_sel", int'(sel), 3);
      check("post32_valid", int'(sel_valid), 1);

      // randomized traffic, model-checked every cycle
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 7) == 0) en = ~en;
         if ($urandom_range(0, 7) == 0) mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0)
            dwell = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 9))
                                                 : DW'($urandom_range(0, 2));
         tick();
      end

      rst = 1'b0; en = 1'b0;
      tick();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/scan_sel_gen.md
SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

Interface
REQ-001 SHALL have parameter DWELL_W, default 8: width of the dwell count.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port en, input, 1: scan enable.
REQ-005 SHALL have port mask, input, 4: channel enable; bit k set means index k takes part in the scan.
REQ-006 SHALL have port dwell, input, DWELL_W: each index is held for dwell+1 cycles.
REQ-007 SHALL have port sel, output, 2: registered index that drives the downstream 2-to-4 decoder select.
REQ-008 SHALL have port sel_valid, output, 1: sel is a live scan index.
REQ-009 SHALL have port wrap, output, 1: one-cycle pulse when the scan returns to a lower or equal index.

Function
REQ-010 SHALL implement a two-state FSM, IDLE and RUN, plus a DWELL_W-bit dwell counter cnt.
REQ-011 In IDLE with en=1 and mask!=0, the block SHALL enter RUN on the next edge, with sel=lowest set bit of mask, sel_valid=1 and cnt=0, giving 1-cycle latency from en.
REQ-012 In IDLE with en=0 or mask=0, sel_valid SHALL stay 0 and sel SHALL hold its value.
REQ-013 In RUN with cnt<dwell, cnt SHALL increment and sel SHALL hold.
REQ-014 In RUN with cnt>=dwell, sel SHALL advance to the next set mask bit above sel, circularly, and cnt SHALL clear. Using >= means a dwell lowered mid-hold advances on the next edge.
REQ-015 wrap SHALL be 1 for exactly the cycle in which an advanced sel is <= its previous value. Otherwise wrap=0.
REQ-016 With a single mask bit set, sel SHALL stay constant and wrap SHALL pulse every dwell+1 cycles.
REQ-017 mask SHALL be sampled only at IDLE->RUN and at each advance. A mask change mid-hold does not cut the current hold short.
REQ-018 If mask=0 at an advance, or en=0 in any RUN cycle, the next state SHALL be IDLE with sel_valid=0, wrap=0, sel held and cnt=0.
REQ-019 If en and rst are both high, rst SHALL win.
REQ-020 dwell=0 SHALL advance every cycle.

Reset
REQ-021 With rst=1 at a clock edge, the block SHALL load state=IDLE, sel=2'b00, sel_valid=0, wrap=0 and cnt=0. This applies in any state, including mid-hold.
REQ-022 After rst deasserts, the block SHALL follow REQ-011 with no extra cycles.

Configuration
REQ-023 With macro SCAN_SEL_ONEHOT_EN defined, the block SHALL add output sel_oh, 4 bits. sel_oh is registered, equals 1<<sel when sel_valid=1, else 4'b0000, and is 4'b0000 in reset.
REQ-024 Without SCAN_SEL_ONEHOT_EN, the sel_oh port and its logic SHALL be absent. All other behaviour is identical.

Structure
REQ-025 The shared package scan_sel_pkg SHALL hold the following:
- the constants N_CH=4 and IDX_W=2;
- the state encodings S_IDLE and S_RUN.
REQ-026 The next-active-index search SHALL be the combinational sub-module scan_next_idx:
- inputs: cur, mask;
- outputs: nxt, wrapped;
- zero mask: nxt=cur, wrapped=0.
REQ-027 The top module SHALL contain only the FSM, the counter and the output registers.

Verification
REQ-028 rst, then en=1, mask=4'b1111, dwell=2:
- sel_valid rises one cycle after en;
- sel sequence is 0,0,0,1,1,1,2,2,2,3,3,3,0;
- wrap=1 only on the cycle sel returns to 0.
REQ-029 mask=4'b1010, dwell=0: sel sequence is 1,3,1,3 changing every cycle, with wrap=1 on each return to 1.
REQ-030 mask=4'b0100, dwell=3: sel=2 constant, with wrap pulsing every 4 cycles.
REQ-031 en dropped on cycle 2 of a dwell=5 hold at sel=1:
- next cycle: sel_valid=0 and sel=1;
- re-enabling with mask=4'b1111 restarts at sel=0 one cycle later.
REQ-032 rst pulsed mid-hold at sel=3, cnt=4: next edge gives sel=0, sel_valid=0, wrap=0.
REQ-033 With SCAN_SEL_ONEHOT_EN and sel=2 valid, sel_oh=4'b0100; in IDLE, sel_oh=4'b0000.
